// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from a first-word-fall-through FIFO and sends each as an 8N1 UART frame
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int POP_WIDTH    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        pop_out,
    output logic        tx,
    output logic        busy,
    output logic        byte_done,
    output logic [15:0] tx_count
);
    typedef enum logic [2:0] {IDLE, POP, START, DATA, STOP} state_t;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] POP_LAST = 16'(POP_WIDTH - 1);
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, tx_count_q, tx_count_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic tx_q, tx_d, pop_q, pop_d, busy_q, busy_d, done_q, done_d, last;
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        sh_d = sh_q;
        last = state_q == POP ? cnt_q == POP_LAST : cnt_q == BIT_LAST;
        case (state_q)
            IDLE: if (en && !fifo_empty) begin
                state_d = POP;
                sh_d = fifo_dout;
            end
            POP: state_d = last ? START : POP;
            START: if (last) begin
                state_d = DATA;
                bit_d = 3'd0;
            end
            DATA: if (last) begin
                sh_d = sh_q >> 1;
                bit_d = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: state_d = last ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == IDLE || last) ? 16'd0 : cnt_q + 16'd1;
        // outputs are decoded from the next state so they change on the same edge as the state
        pop_d = state_d == POP;
        busy_d = state_d != IDLE;
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
        done_d = state_d == STOP && cnt_d == BIT_LAST;
        tx_count_d = tx_count_q + {15'd0, done_d};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            tx_q <= 1'b1;
            pop_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tx_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            tx_q <= tx_d;
            pop_q <= pop_d;
            busy_q <= busy_d;
            done_q <= done_d;
            tx_count_q <= tx_count_d;
        end
    end
    assign pop_out = pop_q;
    assign tx = tx_q;
    assign busy = busy_q;
    assign byte_done = done_q;
    assign tx_count = tx_count_q;
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: table vectors, directed corner sequences and random traffic against a FIFO/UART reference
module tb_fifo_uart_drain;
    localparam int CPB = 4, PW = 10, FRAME = PW + 10 * CPB;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic pop_out, tx, busy, byte_done;
    logic [15:0] tx_count;
    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .POP_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .pop_out(pop_out), .tx(tx), .busy(busy), .byte_done(byte_done), .tx_count(tx_count)
    );
    always #5 clk = ~clk;
    typedef struct { logic [7:0] din; logic [9:0] frame; } vec_t;
    vec_t vecs[5];
    int total = 0, bad = 0;
    logic [7:0] fq[$], exp_q[$];
    int pop_cyc[$];
    int cyc = 0, pops = 0, dones = 0, frames = 0, pushed = 0;
    bit pop_prev = 0, in_frame = 0, ovr = 0;
    logic [9:0] fr;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic drive_fifo();
        fifo_empty = fq.size() == 0;
        fifo_dout = ovr ? 8'hFF : (fq.size() > 0 ? fq[0] : 8'h00);
    endtask
    // FIFO model pops once per pop_out pulse; the tx monitor samples each bit mid-period
    task automatic step();
        int rel, idx;
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_out && !pop_prev) begin
            pops++;
            if (pop_cyc.size() > 0) chk("spacing", cyc - pop_cyc[$] >= FRAME + 1, 1);
            pop_cyc.push_back(cyc);
            if (fq.size() > 0) exp_q.push_back(fq.pop_front());
            in_frame = 1;
            fr = '0;
        end
        pop_prev = pop_out;
        if (byte_done) dones++;
        if (in_frame) begin
            rel = cyc - pop_cyc[$];
            if (rel >= PW && (rel - PW) % CPB == CPB / 2) begin
                idx = (rel - PW) / CPB;
                fr[idx] = tx;
                if (idx == 9) begin
                    in_frame = 0;
                    frames++;
                    e = 8'hxx;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    chk("frame", {22'd0, fr}, {22'd0, 1'b1, e, 1'b0});
                end
            end
        end
        drive_fifo();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        ovr = 0;
        fq.delete();
        drive_fifo();
        step();
        rst = 1'b0;
        exp_q.delete();
        pop_cyc.delete();
        in_frame = 0;
        pop_prev = 0;
        pops = 0;
        dones = 0;
        frames = 0;
    endtask
    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy || (fq.size() > 0 && en)) && n < bound) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, n < bound, 1);
    endtask
    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h01, 10'b1_00000001_0};
        vecs[4] = '{8'h80, 10'b1_10000000_0};
        // reset wins over en and a non-empty FIFO
        rst = 1'b1;
        en = 1'b1;
        fifo_empty = 1'b0;
        fifo_dout = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            step();
            fifo_empty = 1'b0;
            chk("rst_outs", {pop_out, tx, busy, byte_done}, 4'b0100);
            chk("rst_count", tx_count, 0);
        end
        for (int i = 0; i < 5; i++) begin
            do_reset();
            fq.push_back(vecs[i].din);
            drive_fifo();
            en = 1'b1;
            for (int w = 0; w < FRAME; w++) begin
                step();
                chk($sformatf("wave%0d_w%0d", i, w), {pop_out, tx, busy, byte_done},
                    {w < PW, w < PW ? 1'b1 : vecs[i].frame[(w - PW) / CPB], 1'b1, w == FRAME - 1});
            end
            step();
            chk($sformatf("idle%0d", i), {pop_out, tx, busy, byte_done}, 4'b0100);
            chk($sformatf("count%0d", i), tx_count, 1);
            chk($sformatf("pops%0d", i), pops, 1);
            chk($sformatf("dones%0d", i), dones, 1);
        end
        // back-to-back frames from a three-entry FIFO
        do_reset();
        fq = '{8'h01, 8'h02, 8'h03};
        drive_fifo();
        en = 1'b1;
        wait_idle("b2b", 400);
        repeat (5) step();
        chk("b2b_pops", pops, 3);
        chk("b2b_frames", frames, 3);
        chk("b2b_gap1", pop_cyc.size() == 3 ? pop_cyc[1] - pop_cyc[0] : -1, FRAME + 1);
        chk("b2b_gap2", pop_cyc.size() == 3 ? pop_cyc[2] - pop_cyc[1] : -1, FRAME + 1);
        chk("b2b_count", tx_count, 3);
        chk("b2b_idle", {tx, busy}, 2'b10);
        // en dropped during DATA: frame completes, no second pop
        do_reset();
        fq = '{8'h3C, 8'h5A};
        drive_fifo();
        en = 1'b1;
        step();
        repeat (PW + CPB + 6) step();
        en = 1'b0;
        wait_idle("en_off", 200);
        chk("en_off_busy", busy, 0);
        repeat (60) step();
        chk("en_off_pops", pops, 1);
        chk("en_off_frames", frames, 1);
        chk("en_off_left", fq.size(), 1);
        chk("en_off_busy2", busy, 0);
        chk("en_off_count", tx_count, 1);
        // reset pulse during the fifth data bit
        do_reset();
        fq = '{8'h96};
        drive_fifo();
        en = 1'b1;
        step();
        repeat (PW + CPB + 4 * CPB + 1) step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        en = 1'b0;
        step();
        rst = 1'b0;
        in_frame = 0;
        exp_q.delete();
        chk("mid_rst_outs", {pop_out, tx, busy, byte_done}, 4'b0100);
        chk("mid_rst_count", tx_count, 0);
        repeat (60) step();
        chk("mid_rst_dones", dones, 0);
        chk("mid_rst_busy", busy, 0);
        // head byte changes after capture
        do_reset();
        fq = '{8'h3C};
        drive_fifo();
        en = 1'b1;
        step();
        repeat (PW + CPB + 3) step();
        ovr = 1;
        drive_fifo();
        wait_idle("ovr", 200);
        ovr = 0;
        chk("ovr_frames", frames, 1);
        chk("ovr_count", tx_count, 1);
        // tx_count wrap
        do_reset();
        force dut.tx_count_q = 16'hFFFF;
        step();
        release dut.tx_count_q;
        step();
        chk("wrap_pre", tx_count, 16'hFFFF);
        fq = '{8'h77};
        drive_fifo();
        en = 1'b1;
        step();
        wait_idle("wrap", 200);
        chk("wrap_count", tx_count, 0);
        chk("wrap_frames", frames, 1);
        // random traffic with random en toggling
        do_reset();
        pushed = 0;
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0 && fq.size() < 4) begin
                fq.push_back(8'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
            drive_fifo();
            step();
        end
        en = 1'b1;
        wait_idle("rand", 2000);
        repeat (5) step();
        chk("rand_pops", pops, pushed);
        chk("rand_frames", frames, pushed);
        chk("rand_count", tx_count, 16'(pushed));
        chk("rand_pending", exp_q.size(), 0);
        chk("rand_idle", {tx, busy}, 2'b10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
